// File: rtl/daq_header_fifo_node_if.sv
// Header stream / bconv read-side bundle for daq_header_fifo_node.
// master: stream producer plus bconv reader; slave: the FIFO node itself.
interface daq_header_fifo_node_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BCID_W = 12,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              stream_valid;
  logic [DATA_W-1:0] stream_data;
  logic [BCID_W-1:0] stream_bcid;
  logic              bconv_rd_strb;
  logic              bconv_valid;
  logic [DATA_W-1:0] bconv_data;
  logic [BCID_W-1:0] bconv_bcid;
  logic [CW-1:0]     bconv_count;

  modport master (
    output stream_valid, stream_data, stream_bcid, bconv_rd_strb,
    input  bconv_valid, bconv_data, bconv_bcid, bconv_count
  );

  modport slave (
    input  stream_valid, stream_data, stream_bcid, bconv_rd_strb,
    output bconv_valid, bconv_data, bconv_bcid, bconv_count
  );
endinterface

// File: rtl/daq_header_fifo_node.sv
// DAQ header capture node: BCID-window filter feeding a first-word-fall-through
// FIFO read by bconv, with overflow/drop/reject statistics for management.
module daq_header_fifo_node #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BCID_W   = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BCID_MAX = 3564,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk320,
  input  logic                  rst,
  input  logic                  mngt_en,
  input  logic [BCID_W-1:0]     mngt_win_lower,
  input  logic [BCID_W-1:0]     mngt_win_width,
  daq_header_fifo_node_if.slave bus,
  output logic                  stat_overflow,
  output logic [CNT_W-1:0]      stat_drop_cnt,
  output logic [CNT_W-1:0]      stat_rej_cnt,
  output logic [1:0]            state_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned EW    = BCID_W + DATA_W;
  localparam logic [BCID_W:0] BCID_MOD = (BCID_W + 1)'(BCID_MAX);

  typedef enum logic [1:0] {StDis = 2'd0, StRun = 2'd1, StDrain = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              en_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q, wptr_base, rptr_base, wptr_d, rptr_d;
  logic [CW-1:0]     count_q, count_base, count_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_base, drop_d;
  logic [CNT_W-1:0]  rej_q, rej_base, rej_d;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;

  logic [BCID_W:0]   delta;
  logic              in_win, rise, cand, push_req, push, pop, full, drop, rej;

  // Wrap-aware offset of the incoming BCID from the window start.
  always_comb begin
    delta = '0;
    if (bus.stream_bcid >= mngt_win_lower) begin
      delta = {1'b0, bus.stream_bcid} - {1'b0, mngt_win_lower};
    end else begin
      delta = {1'b0, bus.stream_bcid} + BCID_MOD - {1'b0, mngt_win_lower};
    end
    in_win = (delta <= {1'b0, mngt_win_width}) ||
             ({1'b0, mngt_win_width} >= BCID_MOD - 1'b1);
  end

  // Flush on enable rising edge first, then apply this cycle's pop/push/stats.
  always_comb begin
    rise       = mngt_en & ~en_q;
    cand       = bus.stream_valid & mngt_en;
    push_req   = cand & in_win;
    rej        = cand & ~in_win;
    count_base = rise ? '0 : count_q;
    wptr_base  = rise ? '0 : wptr_q;
    rptr_base  = rise ? '0 : rptr_q;
    drop_base  = rise ? '0 : drop_q;
    rej_base   = rise ? '0 : rej_q;
    pop        = bus.bconv_rd_strb & (count_base != '0);
    full       = (count_base == CW'(DEPTH));
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    count_d    = count_base + CW'(push) - CW'(pop);
    wptr_d     = push ? wptr_base + PTR_W'(1) : wptr_base;
    rptr_d     = pop ? rptr_base + PTR_W'(1) : rptr_base;
    ovf_d      = (ovf_q & ~rise) | drop;
    drop_d     = (drop && drop_base != '1) ? drop_base + CNT_W'(1) : drop_base;
    rej_d      = (rej && rej_base != '1) ? rej_base + CNT_W'(1) : rej_base;
  end

  // Next-state logic; DRAIN holds while retained entries are still unread.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDis:   if (mngt_en) state_d = StRun;
      StRun:   if (!mngt_en) state_d = (count_d != '0) ? StDrain : StDis;
      StDrain: begin
        if (mngt_en)               state_d = StRun;
        else if (count_d == '0)    state_d = StDis;
      end
      default: state_d = StDis;
    endcase
  end

  // Control and statistics registers.
  always_ff @(posedge clk320 or posedge rst) begin
    if (rst) begin
      state_q <= StDis;
      en_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= mngt_en;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      rej_q   <= rej_d;
    end
  end

  // Storage array; contents are don't-care until covered by count.
  always_ff @(posedge clk320) begin
    if (push) mem[wptr_base] <= {bus.stream_bcid, bus.stream_data};
  end

  // Head is masked while empty so stale storage never leaks to bconv.
  assign head            = mem[rptr_q];
  assign bus.bconv_valid = (count_q != '0);
  assign bus.bconv_data  = bus.bconv_valid ? head[DATA_W-1:0] : '0;
  assign bus.bconv_bcid  = bus.bconv_valid ? head[EW-1:DATA_W] : '0;
  assign bus.bconv_count = count_q;
  assign stat_overflow   = ovf_q;
  assign stat_drop_cnt   = drop_q;
  assign stat_rej_cnt    = rej_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_daq_header_fifo_node.sv
// Directed plus randomized bench for daq_header_fifo_node against a queue model.
module tb_daq_header_fifo_node;
  localparam int DATA_W = 32, BCID_W = 12, DEPTH = 8, BCID_MAX = 3564, CNT_W = 16;

  logic clk320 = 1'b0;
  logic rst;
  logic mngt_en;
  logic [BCID_W-1:0] mngt_win_lower, mngt_win_width;
  logic stat_overflow;
  logic [CNT_W-1:0] stat_drop_cnt, stat_rej_cnt;
  logic [1:0] state_o;

  daq_header_fifo_node_if #(.DATA_W(DATA_W), .BCID_W(BCID_W), .DEPTH(DEPTH)) bus ();

  daq_header_fifo_node #(
    .DATA_W(DATA_W), .BCID_W(BCID_W), .DEPTH(DEPTH), .BCID_MAX(BCID_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk320(clk320), .rst(rst), .mngt_en(mngt_en),
    .mngt_win_lower(mngt_win_lower), .mngt_win_width(mngt_win_width),
    .bus(bus), .stat_overflow(stat_overflow), .stat_drop_cnt(stat_drop_cnt),
    .stat_rej_cnt(stat_rej_cnt), .state_o(state_o)
  );

  always #5 clk320 = ~clk320;

  // Reference model: queue of {bcid, data}, stats and state as plain integers.
  logic [43:0] q[$];
  int m_ovf, m_drop, m_rej, m_state;
  bit m_en_prev;
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_drop = 0; m_rej = 0; m_state = 0; m_en_prev = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int d, input int b, input bit rd);
    int delta;
    bit popping;
    logic [43:0] e;
    if (en && !m_en_prev) begin
      q.delete(); m_ovf = 0; m_drop = 0; m_rej = 0;
    end
    popping = rd && (q.size() > 0);
    if (v && en) begin
      delta = (b >= int'(mngt_win_lower)) ? b - int'(mngt_win_lower)
                                          : b + BCID_MAX - int'(mngt_win_lower);
      if (delta <= int'(mngt_win_width) || int'(mngt_win_width) >= BCID_MAX - 1) begin
        if (q.size() == DEPTH && !popping) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end else begin
          e = {12'(b), 32'(d)};
          q.push_back(e);
        end
      end else if (m_rej < 65535) m_rej++;
    end
    if (popping) void'(q.pop_front());
    case (m_state)
      0: if (en) m_state = 1;
      1: if (!en) m_state = (q.size() > 0) ? 2 : 0;
      default: if (en) m_state = 1; else if (q.size() == 0) m_state = 0;
    endcase
    m_en_prev = en;
  endtask

  task automatic check_all();
    logic [43:0] h;
    h = (q.size() > 0) ? q[0] : 44'h0;
    chk("valid", bus.bconv_valid, q.size() > 0);
    chk("data", bus.bconv_data, h[31:0]);
    chk("bcid", bus.bconv_bcid, h[43:32]);
    chk("count", bus.bconv_count, q.size());
    chk("overflow", stat_overflow, m_ovf);
    chk("drop_cnt", stat_drop_cnt, m_drop);
    chk("rej_cnt", stat_rej_cnt, m_rej);
    chk("state", state_o, m_state);
  endtask

  task automatic step(input bit en, input bit v, input int d, input int b, input bit rd);
    mngt_en = en; bus.stream_valid = v; bus.stream_data = d;
    bus.stream_bcid = 12'(b); bus.bconv_rd_strb = rd;
    model_step(en, v, d, b, rd);
    @(posedge clk320); #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; mngt_en = 0; mngt_win_lower = 0; mngt_win_width = 0;
    bus.stream_valid = 0; bus.stream_data = 0; bus.stream_bcid = 0; bus.bconv_rd_strb = 0;
    model_reset();
    #2 check_all();
    repeat (2) @(posedge clk320);
    #1 rst = 1'b0;

    // Disabled capture ignores stream.
    step(0, 1, 11, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("dis_state", state_o, 0);

    // Basic push/pop with window 0/0.
    step(1, 1, 33, 0, 0);
    chk("basic_data", bus.bconv_data, 33);
    step(1, 0, 0, 0, 1);
    chk("basic_pop", bus.bconv_valid, 0);

    // Wrap-around window.
    mngt_win_lower = 3560; mngt_win_width = 8;
    step(1, 1, 1, 3559, 0);
    step(1, 1, 2, 3563, 0);
    step(1, 1, 3, 0, 0);
    step(1, 1, 4, 4, 0);
    step(1, 1, 5, 5, 0);
    chk("wrap_rej", stat_rej_cnt, 2);
    chk("wrap_head", bus.bconv_bcid, 3563);
    repeat (3) step(1, 0, 0, 0, 1);

    // Overflow with accept-all window, then push+pop while full.
    mngt_win_width = 12'hfff;
    for (int i = 0; i < 10; i++) step(1, 1, 100 + i, i, 0);
    chk("ovf_count", bus.bconv_count, 8);
    chk("ovf_drop", stat_drop_cnt, 2);
    step(1, 1, 200, 7, 1);
    chk("full_pp_count", bus.bconv_count, 8);
    chk("full_pp_drop", stat_drop_cnt, 2);

    // Drain, partial read, re-enable flush with same-cycle push.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 300 + i, i, 0);
    step(0, 0, 0, 0, 0);
    chk("drain_state", state_o, 2);
    step(0, 0, 0, 0, 1);
    chk("drain_count", bus.bconv_count, 2);
    step(1, 1, 44, 9, 0);
    chk("flush_head", bus.bconv_data, 44);
    chk("flush_count", bus.bconv_count, 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) step(1, 1, 500 + i, i, 0);
    chk("pre_rst_count", bus.bconv_count, 5);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    step(1, 1, 77, 3, 0);
    chk("post_rst_count", bus.bconv_count, 1);

    // Randomized traffic.
    begin
      bit en = 1;
      for (int n = 0; n < 400; n++) begin
        if (n % 40 == 0) begin
          mngt_win_lower = 12'($urandom_range(0, BCID_MAX - 1));
          mngt_win_width = ($urandom_range(0, 7) == 0) ? 12'hfff : 12'($urandom_range(0, 300));
        end
        if ($urandom_range(0, 19) == 0) en = !en;
        step(en, $urandom_range(0, 9) < 6, int'($urandom), $urandom_range(0, BCID_MAX - 1),
             $urandom_range(0, 9) < 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
